// File: rtl/dll_pkg.sv
// Shared data link layer constants and types for the transmit and receive sides.
//   DEF_SEQ_W    : default sequence number width
//   DEF_CRC_POLY : CRC-16 generator polynomial, MSB-first
//   DEF_CRC_INIT : CRC seed
//   state_t      : receive checker FSM states
package dll_pkg;

  localparam int unsigned DEF_SEQ_W   = 12;
  localparam int unsigned CRC_W       = 16;
  localparam int unsigned TLP_W       = 128;
  localparam int unsigned CRC_STEPS   = TLP_W / CRC_W;
  localparam int unsigned STEP_CNT_W  = 3;

  localparam logic [CRC_W-1:0] DEF_CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] DEF_CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/crc16_step.sv
// Combinational fold of 16 data bits into a 16-bit CRC, MSB-first.
//   i_crc   : current CRC value
//   i_data  : 16 data bits, bit 15 folded first
//   o_crc_c : updated CRC (combinational)
module crc16_step
  import dll_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_CRC_POLY
) (
  input  logic [15:0] i_crc,
  input  logic [15:0] i_data,
  output logic [15:0] o_crc_c
);

  logic [15:0] w_crc;

  // Bit-serial LFSR unrolled over the 16 data bits.
  always_comb begin
    w_crc = i_crc;
    for (int i = 15; i >= 0; i--) begin
      w_crc = {w_crc[14:0], 1'b0} ^ ((w_crc[15] ^ i_data[i]) ? POLY : 16'h0000);
    end
  end

  assign o_crc_c = w_crc;

endmodule

// File: rtl/dll_rx_check.sv
// Receive-side data link checker: recomputes the LCRC of each TLP over eight
// 16-bit steps, checks sequence order, forwards good in-order TLPs and returns
// ack/nak pulses to the transmitter's replay buffer.
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : TLP + LCRC + sequence number handshake (ready only in IDLE)
//   tlp_in, crc_in, seq_in : received TLP payload, LCRC, sequence number
//   tlp_out, tlp_out_valid : forwarded TLP and its one-cycle strobe
//   ack, nak, ack_seq      : one-cycle acknowledge pulses and reported sequence
module dll_rx_check
  import dll_pkg::*;
#(
  parameter int unsigned SEQ_W    = DEF_SEQ_W,
  parameter logic [15:0] CRC_INIT = DEF_CRC_INIT,
  parameter logic [15:0] CRC_POLY = DEF_CRC_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     tlp_in,
  input  logic [15:0]      crc_in,
  input  logic [SEQ_W-1:0] seq_in,
  output logic [127:0]     tlp_out,
  output logic             tlp_out_valid,
  output logic             ack,
  output logic             nak,
  output logic [SEQ_W-1:0] ack_seq
);

  state_t                r_state;
  state_t                w_state_nxt;

  logic [127:0]          r_tlp;
  logic [15:0]           r_crc_in;
  logic [SEQ_W-1:0]      r_seq_in;
  logic [15:0]           r_crc;
  logic [STEP_CNT_W-1:0] r_cnt;
  logic [SEQ_W-1:0]      r_next_seq;
  logic                  r_nak_sched;

  logic                  r_in_ready;
  logic [127:0]          r_tlp_out;
  logic                  r_tlp_valid;
  logic                  r_ack;
  logic                  r_nak;
  logic [SEQ_W-1:0]      r_ack_seq;

  logic                  w_accept;
  logic [15:0]           w_crc_step;
  logic [SEQ_W-1:0]      w_d;
  logic [SEQ_W-1:0]      w_prev_seq;
  logic                  w_crc_ok;

  logic                  w_tlp_valid;
  logic                  w_ack;
  logic                  w_nak;
  logic [SEQ_W-1:0]      w_ack_seq;
  logic [127:0]          w_tlp_out;
  logic [SEQ_W-1:0]      w_next_seq;
  logic                  w_nak_sched;

  assign w_accept   = in_valid & r_in_ready;
  assign w_d        = r_seq_in - r_next_seq;
  assign w_prev_seq = r_next_seq - SEQ_W'(1);
  assign w_crc_ok   = (r_crc == r_crc_in);

  crc16_step #(
    .POLY (CRC_POLY)
  ) u_crc16_step (
    .i_crc   (r_crc),
    .i_data  (r_tlp[127:112]),
    .o_crc_c (w_crc_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC:  if (r_cnt == STEP_CNT_W'(CRC_STEPS - 1)) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Decision logic: next values of the response registers and link state.
  always_comb begin
    w_tlp_valid = 1'b0;
    w_ack       = 1'b0;
    w_nak       = 1'b0;
    w_ack_seq   = r_ack_seq;
    w_tlp_out   = r_tlp_out;
    w_next_seq  = r_next_seq;
    w_nak_sched = r_nak_sched;
    if (r_state == ST_CHECK) begin
      if (w_crc_ok && (w_d == '0)) begin
        w_tlp_valid = 1'b1;
        w_tlp_out   = r_tlp;
        w_ack       = 1'b1;
        w_ack_seq   = r_seq_in;
        w_next_seq  = r_next_seq + SEQ_W'(1);
        w_nak_sched = 1'b0;
      end else if (w_crc_ok && w_d[SEQ_W-1]) begin
        // Duplicate: re-acknowledge the last good sequence number.
        w_ack     = 1'b1;
        w_ack_seq = w_prev_seq;
      end else if (!r_nak_sched) begin
        // Bad CRC or lost TLP: one nak until the next good TLP.
        w_nak       = 1'b1;
        w_ack_seq   = w_prev_seq;
        w_nak_sched = 1'b1;
      end
    end
  end

  // Capture and CRC datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tlp    <= '0;
      r_crc_in <= '0;
      r_seq_in <= '0;
      r_crc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tlp    <= tlp_in;
            r_crc_in <= crc_in;
            r_seq_in <= seq_in;
            r_crc    <= CRC_INIT;
            r_cnt    <= '0;
          end
        end
        ST_CALC: begin
          // Rotate so the next word is always at the top; eight rotations
          // restore the original TLP for forwarding.
          r_crc <= w_crc_step;
          r_tlp <= {r_tlp[111:0], r_tlp[127:112]};
          r_cnt <= r_cnt + STEP_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and link state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_tlp_out   <= '0;
      r_tlp_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_nak       <= 1'b0;
      r_ack_seq   <= '0;
      r_next_seq  <= '0;
      r_nak_sched <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_tlp_out   <= w_tlp_out;
      r_tlp_valid <= w_tlp_valid;
      r_ack       <= w_ack;
      r_nak       <= w_nak;
      r_ack_seq   <= w_ack_seq;
      r_next_seq  <= w_next_seq;
      r_nak_sched <= w_nak_sched;
    end
  end

  assign in_ready      = r_in_ready;
  assign tlp_out       = r_tlp_out;
  assign tlp_out_valid = r_tlp_valid;
  assign ack           = r_ack;
  assign nak           = r_nak;
  assign ack_seq       = r_ack_seq;

endmodule
